stream_demux_1_4: RTL and testbench
===================================

Name: stream_demux_1_4

Overview:
- Inverse of the team's 4:1 mux: routes one valid/ready input stream to one of four output channels.
- Each output channel has a one-entry register stage.
- Sits after a shared producer and fans words out to four independent consumers.
- Per-channel transfer counters support debug and verification.

Parameters:
WIDTH, 8, data word width in bits (>=1)
CNT_W, 8, width of each per-channel accepted-word counter (>=1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
up_valid  input  1  input word present
up_ready  output  1  block can accept the word addressed by up_sel this cycle
up_data  input  WIDTH  input word
up_sel  input  2  destination channel 0..3; ignored when ROUND_ROBIN_EN is defined
down_valid  output  4  bit i: channel i holds a word
down_ready  input  4  bit i: consumer i accepts the word
down_data  output  4*WIDTH  channel i word at bits [i*WIDTH +: WIDTH]
cnt  output  4*CNT_W  channel i accepted-word count at bits [i*CNT_W +: CNT_W]

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named rst. All outputs are registered except up_ready.
- Reset values:
  - down_valid = 0, down_data = 0, cnt = 0.
  - Round-robin pointer = 0 when the feature is enabled.
  - up_ready = 1 after reset, because all channels are empty.
- Destination: dst = up_sel, or the round-robin pointer when ROUND_ROBIN_EN is defined.
- up_ready:
  - Combinational: up_ready = ~down_valid[dst] | down_ready[dst].
  - Depends only on dst, channel state and down_ready; never on up_valid.
- Accept: when up_valid & up_ready at a rising edge:
  - down_data[dst] <= up_data.
  - down_valid[dst] <= 1.
  - cnt[dst] <= cnt[dst] + 1.
  - Latency is 1 cycle: the word is visible on down_data[dst] in the next cycle.
- Drain: when down_valid[i] & down_ready[i] and channel i is not refilled in the same cycle, down_valid[i] <= 0.
  - down_data[i] keeps its last value (it is not cleared).
- Simultaneous drain and refill of the same channel:
  - Legal.
  - down_valid[i] stays 1 and down_data[i] takes the new word, giving full throughput of 1 word/cycle per channel.
- Backpressure: while down_valid[i] & ~down_ready[i], down_data[i] and down_valid[i] hold stable.
  - Input words addressed to channel i stall (up_ready = 0).
  - Words addressed to other, non-full channels are still accepted.
- Channels drain independently and concurrently. At most one accept happens per cycle.
- up_valid = 0: no state change on the input side. up_sel is don't-care.
- Counters: modulo 2^CNT_W; all-ones + 1 wraps to 0. Counters are not affected by draining.
- Reset mid-operation: buffered words are discarded, down_valid clears and counters clear, on the edge where rst = 1, regardless of up_valid and down_ready.
- No words are dropped or duplicated. Order is preserved per channel.

Optional Feature:
- Macro: STREAM_DEMUX_ROUND_ROBIN_EN.
- Defined:
  - up_sel is ignored and dst comes from an internal 2-bit pointer that resets to 0.
  - The pointer advances by 1 (3 wraps to 0) only on an accepted word.
  - A stalled target channel blocks the input. The pointer does not skip a full channel.
- Not defined: dst = up_sel, no pointer register exists, and behaviour is exactly as described above.

Test Plan:
- Reset, then sends 0x11/sel0, 0x22/sel1, 0x33/sel2, 0x44/sel3 back-to-back with down_ready=4'b1111 -> each appears on its channel exactly 1 cycle after acceptance with down_valid pulsing 1 cycle; cnt = 1,1,1,1.
- down_ready[2]=0; send 0xA5/sel2, then 0x5A/sel2 -> first accepted, then up_ready=0 with 0xA5 held stable. Raise down_ready[2] -> 0x5A accepted the same cycle and 0x5A appears next cycle; no gap.
- Channel 1 stalled full; send 0x77/sel3 -> up_ready=1, accepted, channel 3 outputs 0x77 while channel 1 still holds its word.
- CNT_W=2, send 5 words to channel 0 -> cnt[0] sequence 1,2,3,0,1.
- Fill channels 0 and 3 with down_ready=0, assert rst for 1 cycle with up_valid=1 -> down_valid=0, cnt=0, no word accepted that cycle; up_ready=1 after reset.
- STREAM_DEMUX_ROUND_ROBIN_EN defined, up_sel held at 2, send 0x01..0x06 -> outputs on channels 0,1,2,3,0,1. With channel 1 stalled, the second word blocks the input until channel 1 drains.

Source files
------------

// File: rtl/stream_demux_1_4.sv
// stream_demux_1_4 -- 1:4 valid/ready stream demultiplexer.
//
// Routes one input stream to one of four output channels. Each channel has
// a one-entry register stage, so each channel can accept a new word on the
// same cycle its consumer takes the old one. Each channel also has a counter
// of the words it has accepted.
//
// Optional feature (macro STREAM_DEMUX_ROUND_ROBIN_EN):
//   up_sel is ignored. The destination comes from an internal 2-bit pointer
//   that resets to 0 and advances only when a word is accepted. The pointer
//   never skips a full channel, so a stalled target blocks the input.
//
// Parameters:
//   WIDTH  data word width in bits
//   CNT_W  width of each per-channel accepted-word counter (wraps modulo 2^CNT_W)
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   up_valid    input word present
//   up_ready    word addressed to the current destination can be taken (combinational)
//   up_data     input word
//   up_sel      destination channel 0..3 (unused in round-robin builds)
//   down_valid  bit i: channel i holds a word
//   down_ready  bit i: consumer i takes the word
//   down_data   channel i word at [i*WIDTH +: WIDTH]
//   cnt         channel i accepted-word count at [i*CNT_W +: CNT_W]

module stream_demux_1_4 #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               up_valid,
   output logic               up_ready,
   input  logic [WIDTH-1:0]   up_data,
   input  logic [1:0]         up_sel,
   output logic [3:0]         down_valid,
   input  logic [3:0]         down_ready,
   output logic [4*WIDTH-1:0] down_data,
   output logic [4*CNT_W-1:0] cnt
);

   logic [1:0]       dst;
   logic             accept;
   logic [3:0]       acc_oh;
   logic [3:0]       vld_q;
   logic [WIDTH-1:0] data_q [4];
   logic [CNT_W-1:0] cnt_q  [4];

`ifdef STREAM_DEMUX_ROUND_ROBIN_EN
   logic [1:0] rr_ptr;
   logic       unused_sel;

   assign unused_sel = ^up_sel;
   assign dst        = rr_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (accept) begin
         rr_ptr <= rr_ptr + 2'd1;
      end
   end
`else
   assign dst = up_sel;
`endif

   // A channel can take a new word if it is empty, or if its consumer
   // drains it on this same edge. up_valid is deliberately not used here.
   assign up_ready = ~vld_q[dst] | down_ready[dst];
   assign accept   = up_valid & up_ready;
   assign acc_oh   = accept ? (4'b0001 << dst) : 4'b0000;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         for (int unsigned i = 0; i < 4; i++) begin
            data_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (acc_oh[i]) begin
               // A refill wins over a drain, so the channel stays valid.
               vld_q[i]  <= 1'b1;
               data_q[i] <= up_data;
               cnt_q[i]  <= cnt_q[i] + CNT_W'(1);
            end else if (down_ready[i]) begin
               // A drain clears only the valid bit. The data stays as it was.
               vld_q[i] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      down_data = '0;
      cnt       = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         down_data[i*WIDTH +: WIDTH] = data_q[i];
         cnt[i*CNT_W +: CNT_W]       = cnt_q[i];
      end
   end

   assign down_valid = vld_q;

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Testbench for stream_demux_1_4 (CNT_W = 2, so counter wrap is exercised).
// The reference model keeps per-channel occupancy, data and counts, and
// updates them from the behavioural rules once per clock.
// Builds with or without STREAM_DEMUX_ROUND_ROBIN_EN.

module tb_stream_demux_1_4;

   localparam int WIDTH = 8;
   localparam int CNT_W = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic               up_valid;
   logic               up_ready;
   logic [WIDTH-1:0]   up_data;
   logic [1:0]         up_sel;
   logic [3:0]         down_valid;
   logic [3:0]         down_ready;
   logic [4*WIDTH-1:0] down_data;
   logic [4*CNT_W-1:0] cnt;

   stream_demux_1_4 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (up_valid),
      .up_ready   (up_ready),
      .up_data    (up_data),
      .up_sel     (up_sel),
      .down_valid (down_valid),
      .down_ready (down_ready),
      .down_data  (down_data),
      .cnt        (cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model
   bit      m_known = 0;
   bit      m_vld  [4];
   int      m_data [4];
   int      m_cnt  [4];
   int      m_ptr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int dest(input logic [1:0] s);
`ifdef STREAM_DEMUX_ROUND_ROBIN_EN
      return m_ptr;
`else
      return int'(s);
`endif
   endfunction

   // Drive one cycle of inputs, check the DUT against the model, then advance both.
   task automatic step(input logic r, input logic v, input logic [1:0] s,
                       input logic [7:0] d, input logic [3:0] dr);
      int  dst;
      bit  exp_rdy;
      bit  acc;
      rst = r; up_valid = v; up_sel = s; up_data = d; down_ready = dr;
      #2;
      dst     = dest(s);
      exp_rdy = !m_vld[dst] || dr[dst];
      if (m_known) begin
         chk("up_ready", 32'(up_ready), 32'(exp_rdy));
         for (int ch = 0; ch < 4; ch++) begin
            chk($sformatf("down_valid[%0d]", ch), 32'(down_valid[ch]), 32'(m_vld[ch]));
            chk($sformatf("down_data[%0d]", ch), 32'(down_data[ch*WIDTH +: WIDTH]), 32'(m_data[ch]));
            chk($sformatf("cnt[%0d]", ch), 32'(cnt[ch*CNT_W +: CNT_W]), 32'(m_cnt[ch]));
         end
      end
      if (r) begin
         for (int ch = 0; ch < 4; ch++) begin
            m_vld[ch] = 0; m_data[ch] = 0; m_cnt[ch] = 0;
         end
         m_ptr   = 0;
         m_known = 1;
      end else begin
         acc = v && exp_rdy;
         for (int ch = 0; ch < 4; ch++) begin
            if (acc && ch == dst) begin
               m_vld[ch]  = 1;
               m_data[ch] = int'(d);
               m_cnt[ch]  = (m_cnt[ch] + 1) % (1 << CNT_W);
            end else if (dr[ch]) begin
               m_vld[ch] = 0;
            end
         end
         if (acc) m_ptr = (m_ptr + 1) % 4;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; up_valid = 1'b0; up_sel = '0; up_data = '0; down_ready = '0;
      @(posedge clk);
      #1;
      step(1, 0, 0, 8'h00, 4'hF);
      step(1, 1, 0, 8'hEE, 4'h0);
      chk("reset down_valid", 32'(down_valid), 32'h0);
      chk("reset cnt", 32'(cnt), 32'h0);
      chk("reset up_ready", 32'(up_ready), 32'h1);

`ifndef STREAM_DEMUX_ROUND_ROBIN_EN
      // back-to-back words to each channel, 1-cycle latency
      step(0, 1, 0, 8'h11, 4'hF);
      chk("t1 valid0", 32'(down_valid), 32'b0001);
      chk("t1 data0", 32'(down_data[7:0]), 32'h11);
      step(0, 1, 1, 8'h22, 4'hF);
      chk("t1 valid1", 32'(down_valid), 32'b0010);
      step(0, 1, 2, 8'h33, 4'hF);
      step(0, 1, 3, 8'h44, 4'hF);
      chk("t1 data3", 32'(down_data[31:24]), 32'h44);
      step(0, 0, 0, 8'h00, 4'hF);
      chk("t1 cnt", 32'(cnt), 32'b01_01_01_01);

      // backpressure on channel 2, then release with same-cycle refill
      step(0, 1, 2, 8'hA5, 4'b1011);
      step(0, 1, 2, 8'h5A, 4'b1011);
      chk("t2 hold", 32'(down_data[23:16]), 32'hA5);
      step(0, 1, 2, 8'h5A, 4'b1111);
      chk("t2 refill", 32'(down_data[23:16]), 32'h5A);
      chk("t2 valid", 32'(down_valid[2]), 32'h1);

      // stalled channel 1 does not block channel 3
      step(0, 1, 1, 8'h66, 4'b1101);
      step(0, 1, 3, 8'h77, 4'b1101);
      chk("t3 ch3", 32'(down_data[31:24]), 32'h77);
      chk("t3 ch1", 32'(down_data[15:8]), 32'h66);
      chk("t3 valid", 32'(down_valid), 32'b1010);

      // reset while channels 0 and 3 are full and up_valid is high
      step(0, 1, 0, 8'h81, 4'h0);
      step(0, 1, 3, 8'h83, 4'h0);
      step(1, 1, 1, 8'h99, 4'h0);
      chk("t5 valid", 32'(down_valid), 32'h0);
      chk("t5 cnt", 32'(cnt), 32'h0);
      chk("t5 up_ready", 32'(up_ready), 32'h1);

      // counter wrap: 1,2,3,0,1
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 0, 8'(8'hC0 + i), 4'hF);
         chk("t4 cnt0", 32'(cnt[1:0]), 32'((i + 1) % 4));
      end
`else
      // up_sel held at 2, words spread 0,1,2,3,0,1
      for (int i = 1; i <= 6; i++) begin
         step(0, 1, 2, 8'(i), 4'hF);
         chk("rr valid", 32'(down_valid), 32'(1 << ((i - 1) % 4)));
      end
      step(1, 0, 2, 8'h00, 4'hF);
      // fill all four with channel 1 stalled, then the 2nd word of the next round blocks
      for (int i = 0; i < 4; i++) step(0, 1, 2, 8'(8'hB0 + i), 4'b1101);
      step(0, 1, 2, 8'hB4, 4'b1101);
      step(0, 1, 2, 8'hB5, 4'b1101);
      step(0, 1, 2, 8'hB5, 4'b1101);
      chk("rr blocked", 32'(down_data[15:8]), 32'hB1);
      step(0, 1, 2, 8'hB5, 4'b1111);
      chk("rr released", 32'(down_data[15:8]), 32'hB5);
`endif

      // randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
              1'($urandom_range(0, 3) != 0),
              2'($urandom),
              8'($urandom),
              4'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
